// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin system-bus arbiter: FSM state encoding and
// the grant-index width helper (at least one bit, even for a single core).
package arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_SWITCH = 2'd2,
      ST_SETTLE = 2'd3
   } arb_state_e;

   function automatic int gw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Combinational successor pick: rotate from grant, first candidate wins; zero latency, no flow control.
// ARB_SKIP_IDLE_EN: candidates must have core_req set, else plain (grant+1) mod NCORES.
module rr_next_pick #(
   parameter int NCORES = 2,
   parameter int GW     = 1
) (
   input  logic [GW-1:0]     grant,
   input  logic [NCORES-1:0] core_req,
   output logic [GW-1:0]     next
);

`ifdef ARB_SKIP_IDLE_EN
   int   idx;
   logic found;

   // Falls back to the current owner when nobody else is asking, so no switch happens.
   always_comb begin
      next  = grant;
      idx   = 0;
      found = 1'b0;
      for (int k = 1; k < NCORES; k++) begin
         idx = (int'(grant) + k) % NCORES;
         if (!found && core_req[idx]) begin
            next  = GW'(idx);
            found = 1'b1;
         end
      end
   end
`else
   logic unused_core_req;
   assign unused_core_req = ^core_req;

   // True modulo so non-power-of-two counts wrap correctly; NCORES==1 yields grant.
   always_comb begin
      next = GW'((int'(grant) + 1) % NCORES);
   end
`endif

endmodule

// File: rtl/nbus_arbiter.sv
// Time-sliced round-robin owner of the shared system bus; grant switches only at owner's idle point.
// Output mux/demux is combinational on grant; non-owners are always held busy. Option: ARB_SKIP_IDLE_EN.
module nbus_arbiter
   import arb_pkg::*;
#(
   parameter  int NCORES    = 2,
   parameter  int MW        = 150,
   parameter  int SW        = 98,
   parameter  int SLICE_MIN = 1,
   localparam int GW        = gw(NCORES)
) (
   input  logic                 CLK,
   input  logic                 RST_X,
   input  logic                 init_done,
   input  logic                 sys_busy,
   input  logic [NCORES-1:0]    core_idle,
   input  logic [NCORES-1:0]    core_req,
   input  logic [NCORES*MW-1:0] m_bundle,
   input  logic [SW-1:0]        s_resp,
   output logic [MW-1:0]        bus_bundle,
   output logic [NCORES*SW-1:0] core_resp,
   output logic [NCORES-1:0]    core_busy,
   output logic [GW-1:0]        grant
);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [GW-1:0] next;

   rr_next_pick #(
      .NCORES (NCORES),
      .GW     (GW)
   ) u_pick (
      .grant    (grant_q),
      .core_req (core_req),
      .next     (next)
   );

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state_q <= ST_RUN;
         grant_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // Everything freezes while init_done is low, including a half-finished switch.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      if (init_done) begin
         case (state_q)
            ST_RUN: begin
               if (core_idle[grant_q] && (next != grant_q)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
               grant_d = next;
               state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
            default: begin
               if (cnt_q < 8'(SLICE_MIN)) cnt_d = cnt_q + 8'd1;
               else                        state_d = ST_RUN;
            end
         endcase
      end
   end

   always_comb begin
      bus_bundle = m_bundle[int'(grant_q)*MW +: MW];
      core_resp  = '0;
      core_resp[int'(grant_q)*SW +: SW] = s_resp;
      core_busy  = '1;
      core_busy[grant_q] = ((state_q == ST_RUN) || (state_q == ST_SETTLE)) ? sys_busy : 1'b1;
   end

   assign grant = grant_q;

endmodule

// File: tb/tb_nbus_arbiter.sv
// Directed bench for nbus_arbiter: 1-, 2- and 3-core instances (plus a 4-core one with ARB_SKIP_IDLE_EN).
module tb_nbus_arbiter;
   import arb_pkg::*;

   logic clk, rst_n, init_done, sys_busy;
   logic [7:0] s_resp;
   int passed, total;

   // NCORES = 1
   logic        c1_idle, c1_req;
   logic [15:0] m1, bus1;
   logic [7:0]  resp1;
   logic        busy1;
   logic [0:0]  grant1;
   // NCORES = 2
   logic [1:0]  c2_idle, c2_req;
   logic [31:0] m2;
   logic [15:0] bus2, resp2;
   logic [1:0]  busy2;
   logic [0:0]  grant2;
   // NCORES = 3
   logic [2:0]  c3_idle, c3_req;
   logic [47:0] m3;
   logic [15:0] bus3;
   logic [23:0] resp3;
   logic [2:0]  busy3;
   logic [1:0]  grant3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   nbus_arbiter #(.NCORES(1), .MW(16), .SW(8), .SLICE_MIN(1)) u1 (
      .CLK(clk), .RST_X(rst_n), .init_done(init_done), .sys_busy(sys_busy),
      .core_idle(c1_idle), .core_req(c1_req), .m_bundle(m1), .s_resp(s_resp),
      .bus_bundle(bus1), .core_resp(resp1), .core_busy(busy1), .grant(grant1));

   nbus_arbiter #(.NCORES(2), .MW(16), .SW(8), .SLICE_MIN(1)) u2 (
      .CLK(clk), .RST_X(rst_n), .init_done(init_done), .sys_busy(sys_busy),
      .core_idle(c2_idle), .core_req(c2_req), .m_bundle(m2), .s_resp(s_resp),
      .bus_bundle(bus2), .core_resp(resp2), .core_busy(busy2), .grant(grant2));

   nbus_arbiter #(.NCORES(3), .MW(16), .SW(8), .SLICE_MIN(1)) u3 (
      .CLK(clk), .RST_X(rst_n), .init_done(init_done), .sys_busy(sys_busy),
      .core_idle(c3_idle), .core_req(c3_req), .m_bundle(m3), .s_resp(s_resp),
      .bus_bundle(bus3), .core_resp(resp3), .core_busy(busy3), .grant(grant3));

`ifdef ARB_SKIP_IDLE_EN
   logic [3:0]  c4_idle, c4_req;
   logic [63:0] m4;
   logic [15:0] bus4;
   logic [31:0] resp4;
   logic [3:0]  busy4;
   logic [1:0]  grant4;

   nbus_arbiter #(.NCORES(4), .MW(16), .SW(8), .SLICE_MIN(1)) u4 (
      .CLK(clk), .RST_X(rst_n), .init_done(init_done), .sys_busy(sys_busy),
      .core_idle(c4_idle), .core_req(c4_req), .m_bundle(m4), .s_resp(s_resp),
      .bus_bundle(bus4), .core_resp(resp4), .core_busy(busy4), .grant(grant4));
`endif

   task automatic test_reset();
      rst_n = 1'b1; init_done = 1'b0; sys_busy = 1'b0; s_resp = 8'h00;
      c1_idle = 1'b1; c1_req = 1'b1; m1 = 16'h7E7E;
      c2_idle = 2'b00; c2_req = 2'b11; m2 = {16'hA5A5, 16'h1234};
      c3_idle = 3'b000; c3_req = 3'b111; m3 = {16'h3333, 16'h2222, 16'h1111};
`ifdef ARB_SKIP_IDLE_EN
      c4_idle = 4'b0000; c4_req = 4'b0000; m4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
`endif
      #2 rst_n = 1'b0;
      #1;
      total++; if (grant2 !== 1'b0) $display("FAIL reset_grant2: got %0d want 0", grant2); else passed++;
      total++; if (grant3 !== 2'd0) $display("FAIL reset_grant3: got %0d want 0", grant3); else passed++;
      total++; if (u2.state_q !== ST_RUN) $display("FAIL reset_state2: got %0d want 0", u2.state_q); else passed++;
      total++; if (busy2 !== 2'b10) $display("FAIL reset_busy2: got %b want 10", busy2); else passed++;
      total++; if (busy3 !== 3'b110) $display("FAIL reset_busy3: got %b want 110", busy3); else passed++;
      sys_busy = 1'b1;
      #1;
      total++; if (busy2 !== 2'b11) $display("FAIL reset_busy2_sys: got %b want 11", busy2); else passed++;
      total++; if (bus2 !== 16'h1234) $display("FAIL reset_bus2: got %h want 1234", bus2); else passed++;
      sys_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; init_done = 1'b1;
   endtask

   // Two cores, both idle: 5-cycle rhythm SWITCH, SETTLE, SETTLE, RUN, HOLD per owner.
   task automatic test_rotate2();
      logic       g_tab [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] b_tab [12] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11,
                                 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
      logic [15:0] exp_bus;
      @(posedge clk); #1;
      c2_idle = 2'b11;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         exp_bus = g_tab[n] ? 16'hA5A5 : 16'h1234;
         total++; if (grant2 !== g_tab[n]) $display("FAIL rot2_grant[%0d]: got %0d want %0d", n, grant2, g_tab[n]); else passed++;
         total++; if (busy2 !== b_tab[n]) $display("FAIL rot2_busy[%0d]: got %b want %b", n, busy2, b_tab[n]); else passed++;
         total++; if (bus2 !== exp_bus) $display("FAIL rot2_bus[%0d]: got %h want %h", n, bus2, exp_bus); else passed++;
      end
   endtask

   // Owner 1 never idle: grant stays, only owner sees sys_busy and s_resp.
   task automatic test_owner_idle();
      c2_idle = 2'b00;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         sys_busy = i[0];
         s_resp   = 8'h5A ^ i[7:0];
         #1;
         total++; if (grant2 !== 1'b1) $display("FAIL idle_grant2[%0d]: got %0d want 1", i, grant2); else passed++;
         total++; if (busy2 !== {sys_busy, 1'b1}) $display("FAIL idle_busy2[%0d]: got %b want %b", i, busy2, {sys_busy, 1'b1}); else passed++;
         total++; if (resp2 !== {s_resp, 8'h00}) $display("FAIL idle_resp2[%0d]: got %h want %h", i, resp2, {s_resp, 8'h00}); else passed++;
         total++; if (bus2 !== 16'hA5A5) $display("FAIL idle_bus2[%0d]: got %h want a5a5", i, bus2); else passed++;
         total++; if (resp3 !== {16'h0000, s_resp}) $display("FAIL idle_resp3[%0d]: got %h want %h", i, resp3, {16'h0000, s_resp}); else passed++;
         total++; if (busy1 !== sys_busy || grant1 !== 1'b0) $display("FAIL single_core[%0d]: got busy %b grant %0d want busy %b grant 0", i, busy1, grant1, sys_busy); else passed++;
         total++; if (resp1 !== s_resp || bus1 !== 16'h7E7E) $display("FAIL single_mux[%0d]: got resp %h bus %h want %h 7e7e", i, resp1, bus1, s_resp); else passed++;
      end
      sys_busy = 1'b0; s_resp = 8'h00;
   endtask

   // Three cores: 0->1->2->0 wrap, never index 3.
   task automatic test_wrap3();
      logic [1:0] exp_g;
`ifdef ARB_SKIP_IDLE_EN
      c3_req = 3'b111;
`else
      c3_req = 3'b001;
`endif
      c3_idle = 3'b111;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         exp_g = (n < 2) ? 2'd0 : 2'(((n - 2) / 5 + 1) % 3);
         total++; if (grant3 !== exp_g) $display("FAIL wrap3_grant[%0d]: got %0d want %0d", n, grant3, exp_g); else passed++;
      end
      c3_idle = 3'b000;
      c3_req  = 3'b111;
   endtask

   task automatic test_freeze_reset();
      c2_idle = 2'b11;
      @(posedge clk); #1;
      total++; if (u2.state_q !== ST_HOLD || grant2 !== 1'b1) $display("FAIL frz_enter: got state %0d grant %0d want 1 1", u2.state_q, grant2); else passed++;
      init_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if (u2.state_q !== ST_HOLD || grant2 !== 1'b1 || busy2 !== 2'b11)
            $display("FAIL frz_hold[%0d]: got state %0d grant %0d busy %b want 1 1 11", i, u2.state_q, grant2, busy2); else passed++;
      end
      init_done = 1'b1;
      @(posedge clk); #1;
      total++; if (u2.state_q !== ST_SWITCH || grant2 !== 1'b0) $display("FAIL frz_resume: got state %0d grant %0d want 2 0", u2.state_q, grant2); else passed++;
      repeat (5) @(posedge clk);
      #1;
      total++; if (u2.state_q !== ST_SWITCH || grant2 !== 1'b1) $display("FAIL pre_rst: got state %0d grant %0d want 2 1", u2.state_q, grant2); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (grant2 !== 1'b0 || u2.state_q !== ST_RUN) $display("FAIL async_rst: got grant %0d state %0d want 0 0", grant2, u2.state_q); else passed++;
      total++; if (busy2 !== 2'b10 || grant3 !== 2'd0) $display("FAIL async_rst_out: got busy2 %b grant3 %0d want 10 0", busy2, grant3); else passed++;
      c2_idle = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (grant2 !== 1'b0 || u2.state_q !== ST_RUN) $display("FAIL post_rst: got grant %0d state %0d want 0 0", grant2, u2.state_q); else passed++;
   endtask

`ifdef ARB_SKIP_IDLE_EN
   task automatic test_skip();
      logic [1:0] exp_g;
      c4_req  = 4'b1001;
      c4_idle = 4'b1111;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         exp_g = (n < 2) ? 2'd0 : ((((n - 2) / 5) % 2 == 0) ? 2'd3 : 2'd0);
         total++; if (grant4 !== exp_g) $display("FAIL skip_grant[%0d]: got %0d want %0d", n, grant4, exp_g); else passed++;
      end
      c4_req = 4'b1000;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         total++; if (grant4 !== 2'd3 || busy4 !== 4'b0111) $display("FAIL skip_alone[%0d]: got grant %0d busy %b want 3 0111", n, grant4, busy4); else passed++;
      end
   endtask
`endif

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_rotate2();
      test_owner_idle();
      test_wrap3();
      test_freeze_reset();
`ifdef ARB_SKIP_IDLE_EN
      test_skip();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
